id_inst_capture: RTL

- Consumer side of the fetch interface. IF drives the fetch address into the synchronous-read BIOS and IMEM, and registers id_pc/id_inst_sel.
- This block sits in ID and selects the returned instruction word using id_inst_sel.
- It preserves the word across ID stalls, because the memories keep reading the held IF address, so their outputs no longer match the stalled instruction.
- It squashes the wrong-path word after a redirect to a NOP bubble.
- It keeps fetch and bubble performance counters for the CSR file.

---
 rtl/id_inst_capture.sv | 108 ++++++++++
 1 files changed

// File: rtl/id_inst_capture.sv
// ID-stage instruction capture: selects the synchronous memory read word, holds it
// across ID stalls, squashes wrong-path words after a redirect and counts fetches/bubbles.

module id_perf_counter #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] cnt
);
    // Wraps modulo 2^COUNT_WIDTH; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
endmodule

module id_inst_capture #(
    parameter logic [31:0] NOP         = 32'h0000_0013,
    parameter int          COUNT_WIDTH = 32,
    parameter logic [1:0]  INST_BIOS   = 2'b00,
    parameter logic [1:0]  INST_IMEM   = 2'b01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_stall,
    input  logic                   flush,
    input  logic [1:0]             id_inst_sel,
    input  logic [31:0]            bios_dout,
    input  logic [31:0]            imem_dout,
    input  logic                   counters_clr,
    output logic [31:0]            id_inst,
    output logic                   id_inst_valid,
    output logic [COUNT_WIDTH-1:0] inst_count,
    output logic [COUNT_WIDTH-1:0] bubble_count
);
    typedef enum logic [1:0] {KILL, LIVE, HELD} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] sel_word;

    always_comb begin
        sel_word = NOP;
        if (id_inst_sel == INST_BIOS)      sel_word = bios_dout;
        else if (id_inst_sel == INST_IMEM) sel_word = imem_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= KILL;
            hold_q  <= NOP;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        id_inst       = NOP;
        id_inst_valid = 1'b0;
        case (state_q)
            LIVE: begin
                id_inst       = sel_word;
                id_inst_valid = 1'b1;
                if (id_stall) begin
                    state_d = HELD;
                    hold_d  = sel_word;
                end
            end
            HELD: begin
                id_inst       = hold_q;
                id_inst_valid = 1'b1;
                // Memories re-read the held IF address, so dout is correct again next cycle.
                if (!id_stall) state_d = LIVE;
            end
            default: begin
                if (!id_stall) state_d = LIVE;
            end
        endcase
        // IF reloads id_pc on a redirect even when stalled, so flush beats stall.
        if (flush) state_d = KILL;
    end

    logic [1:0]                  cnt_inc;
    logic [1:0][COUNT_WIDTH-1:0] cnt_val;

    assign cnt_inc[0] = !id_stall &&  id_inst_valid;
    assign cnt_inc[1] = !id_stall && !id_inst_valid;

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        id_perf_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (counters_clr),
            .inc (cnt_inc[g]),
            .cnt (cnt_val[g])
        );
    end

    assign inst_count   = cnt_val[0];
    assign bubble_count = cnt_val[1];
endmodule
